// File: rtl/modaddsub_iter_if.sv
// Request/response bundle for the iterative modular add/sub/reduce unit.
//  master: requester side (drives in_vld, mode, op1, op2, mod, tag_in, out_rdy)
//  slave : unit side      (drives in_rdy, out_vld, res, err, tag_out, iters)
interface modaddsub_iter_if #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned MAXITER = 8
);
    localparam int unsigned CNTW = $clog2(MAXITER + 1);

    // request channel
    logic             in_vld;
    logic             in_rdy;
    logic [1:0]       mode;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] mod;
    logic [TAGW-1:0]  tag_in;

    // response channel
    logic             out_vld;
    logic             out_rdy;
    logic [WIDTH-1:0] res;
    logic             err;
    logic [TAGW-1:0]  tag_out;
    logic [CNTW-1:0]  iters;

    modport master (
        output in_vld, mode, op1, op2, mod, tag_in, out_rdy,
        input  in_rdy, out_vld, res, err, tag_out, iters
    );

    modport slave (
        input  in_vld, mode, op1, op2, mod, tag_in, out_rdy,
        output in_rdy, out_vld, res, err, tag_out, iters
    );
endinterface

// File: rtl/modaddsub_iter.sv
// Iterative modular add / subtract / reduce unit.
// res = (op1 +/- op2) mod p, or op1 mod p, reached by repeated +/-p corrections.
// One operation in flight; the tag travels with it unchanged.
// Ports:
//  clk  - rising-edge clock
//  rst  - asynchronous reset, active-low
//  bus  - modaddsub_iter_if.slave: request (in_vld/in_rdy, mode, op1, op2, mod, tag_in)
//         and response (out_vld/out_rdy, res, err, tag_out, iters)
module modaddsub_iter #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned TAGW    = 4,
    parameter int unsigned MAXITER = 8
) (
    input  logic              clk,
    input  logic              rst,
    modaddsub_iter_if.slave   bus
);
    localparam int unsigned CNTW = $clog2(MAXITER + 1);
    // Two guard bits: enough headroom for op1+op2 and for op1-op2 going negative.
    localparam int unsigned ACCW = WIDTH + 2;

    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_RED = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]        p_q, p_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [TAGW-1:0]         tag_q, tag_d;
    logic                    in_rdy_q, in_rdy_d;
    logic                    out_vld_q, out_vld_d;
    logic [WIDTH-1:0]        res_q, res_d;
    logic                    err_q, err_d;
    logic [CNTW-1:0]         iters_q, iters_d;

    logic signed [ACCW-1:0]  op1_ext;
    logic signed [ACCW-1:0]  op2_ext;
    logic signed [ACCW-1:0]  p_ext;
    logic signed [ACCW-1:0]  acc_cap;
    logic                    acc_neg;
    logic                    acc_big;

    // Operand extension and capture value for the incoming request.
    always_comb begin
        op1_ext = ACCW'(bus.op1);
        op2_ext = ACCW'(bus.op2);
        p_ext   = ACCW'(p_q);
        acc_neg = acc_q[ACCW-1];
        acc_big = !acc_neg && (acc_q >= p_ext);
        case (bus.mode)
            MODE_SUB: acc_cap = op1_ext - op2_ext;
            MODE_RED: acc_cap = op1_ext;
            default:  acc_cap = op1_ext + op2_ext;
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        out_vld_d = out_vld_q;
        res_d     = res_q;
        err_d     = err_q;
        iters_d   = iters_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_vld && in_rdy_q) begin
                    acc_d = acc_cap;
                    p_d   = bus.mod;
                    tag_d = bus.tag_in;
                    cnt_d = '0;
                    if (bus.mod == '0) begin
                        res_d     = '0;
                        err_d     = 1'b1;
                        iters_d   = '0;
                        out_vld_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_REDUCE;
                    end
                end
            end
            S_REDUCE: begin
                if (acc_neg || acc_big) begin
                    if (cnt_q == CNTW'(MAXITER)) begin
                        res_d     = '0;
                        err_d     = 1'b1;
                        iters_d   = CNTW'(MAXITER);
                        out_vld_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        acc_d = acc_neg ? (acc_q + p_ext) : (acc_q - p_ext);
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    res_d     = acc_q[WIDTH-1:0];
                    err_d     = 1'b0;
                    iters_d   = cnt_q;
                    out_vld_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (out_vld_q && bus.out_rdy) begin
                    out_vld_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so that in_rdy stays low while reset is asserted.
        in_rdy_d = (state_d == S_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            tag_q     <= '0;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
            res_q     <= '0;
            err_q     <= 1'b0;
            iters_q   <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
            res_q     <= res_d;
            err_q     <= err_d;
            iters_q   <= iters_d;
        end
    end

    assign bus.in_rdy  = in_rdy_q;
    assign bus.out_vld = out_vld_q;
    assign bus.res     = res_q;
    assign bus.err     = err_q;
    assign bus.tag_out = tag_q;
    assign bus.iters   = iters_q;

endmodule

// File: tb/tb_modaddsub_iter.sv
// Directed bench for modaddsub_iter (WIDTH=12, TAGW=4, MAXITER=8, p=3329).
module tb_modaddsub_iter;
    localparam int unsigned WIDTH   = 12;
    localparam int unsigned TAGW    = 4;
    localparam int unsigned MAXITER = 8;
    localparam int unsigned CNTW    = $clog2(MAXITER + 1);
    localparam logic [WIDTH-1:0] P  = 12'd3329;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    modaddsub_iter_if #(.WIDTH(WIDTH), .TAGW(TAGW), .MAXITER(MAXITER)) bus ();

    modaddsub_iter #(.WIDTH(WIDTH), .TAGW(TAGW), .MAXITER(MAXITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request, waits for acceptance, counts edges (accepting edge = 1)
    // until out_vld is seen. Returns at a negedge with out_vld up (or timed out).
    task automatic do_op(input logic [1:0] m, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] p,
                         input logic [TAGW-1:0] t, output int edges, output bit tmo);
        int wait_cyc;
        bus.in_vld = 1'b1;
        bus.mode   = m;
        bus.op1    = a;
        bus.op2    = b;
        bus.mod    = p;
        bus.tag_in = t;
        edges      = 0;
        tmo        = 1'b0;
        wait_cyc   = 0;
        while (bus.in_rdy !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (bus.in_rdy !== 1'b1) begin
            tmo        = 1'b1;
            bus.in_vld = 1'b0;
        end else begin
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            bus.in_vld = 1'b0;
            while (bus.out_vld !== 1'b1 && edges < 40) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            tmo = (bus.out_vld !== 1'b1);
        end
    endtask

    // Lets the pending result handshake (out_rdy high) and returns to IDLE.
    task automatic drain();
        int n;
        bus.out_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.in_rdy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        bus.in_vld  = 1'b0;
        bus.mode    = 2'b00;
        bus.op1     = '0;
        bus.op2     = '0;
        bus.mod     = P;
        bus.tag_in  = '0;
        bus.out_rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_rdy !== 1'b0 || bus.out_vld !== 1'b0 || bus.res !== '0 ||
            bus.err !== 1'b0 || bus.tag_out !== '0 || bus.iters !== '0) begin
            failures++;
            $display("FAIL reset_state: in_rdy=%b out_vld=%b res=%0d err=%b tag=%0d iters=%0d, want 0 0 0 0 0 0",
                     bus.in_rdy, bus.out_vld, bus.res, bus.err, bus.tag_out, bus.iters);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy: in_rdy=%b want 1", bus.in_rdy);
        end
    endtask

    task automatic test_add();
        int e; bit t;
        do_op(2'b00, 12'd3000, 12'd1000, P, 4'd5, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd671 || bus.err !== 1'b0 ||
            bus.iters !== CNTW'(1) || bus.tag_out !== 4'd5 || e != 3) begin
            failures++;
            $display("FAIL add_3000_1000: tmo=%b res=%0d err=%b iters=%0d tag=%0d edges=%0d, want 0 671 0 1 5 3",
                     t, bus.res, bus.err, bus.iters, bus.tag_out, e);
        end
        drain();
        do_op(2'b11, 12'd3000, 12'd1000, P, 4'd6, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd671 || bus.err !== 1'b0 || bus.tag_out !== 4'd6) begin
            failures++;
            $display("FAIL mode11_add: tmo=%b res=%0d err=%b tag=%0d, want 0 671 0 6",
                     t, bus.res, bus.err, bus.tag_out);
        end
        drain();
    endtask

    task automatic test_sub();
        int e; bit t;
        do_op(2'b01, 12'd5, 12'd10, P, 4'd1, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd3324 || bus.err !== 1'b0 || bus.iters !== CNTW'(1)) begin
            failures++;
            $display("FAIL sub_5_10: tmo=%b res=%0d err=%b iters=%0d, want 0 3324 0 1",
                     t, bus.res, bus.err, bus.iters);
        end
        drain();
        do_op(2'b01, 12'd7, 12'd7, P, 4'd2, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd0 || bus.iters !== CNTW'(0) || e != 2) begin
            failures++;
            $display("FAIL sub_7_7: tmo=%b res=%0d iters=%0d edges=%0d, want 0 0 0 2",
                     t, bus.res, bus.iters, e);
        end
        drain();
    endtask

    task automatic test_red();
        int e; bit t;
        do_op(2'b10, 12'd4095, 12'd123, P, 4'd3, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd766 || bus.iters !== CNTW'(1) || bus.err !== 1'b0) begin
            failures++;
            $display("FAIL red_4095: tmo=%b res=%0d iters=%0d err=%b, want 0 766 1 0",
                     t, bus.res, bus.iters, bus.err);
        end
        drain();
        do_op(2'b00, 12'd3329, 12'd0, P, 4'd4, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd0 || bus.iters !== CNTW'(1) || e != 3) begin
            failures++;
            $display("FAIL acc_eq_p: tmo=%b res=%0d iters=%0d edges=%0d, want 0 0 1 3",
                     t, bus.res, bus.iters, e);
        end
        drain();
    endtask

    task automatic test_err();
        int e; bit t;
        do_op(2'b00, 12'd1, 12'd1, 12'd0, 4'd7, e, t);
        checks++;
        if (t !== 1'b0 || bus.err !== 1'b1 || bus.res !== 12'd0 || bus.iters !== CNTW'(0) ||
            bus.tag_out !== 4'd7) begin
            failures++;
            $display("FAIL mod_zero: tmo=%b err=%b res=%0d iters=%0d tag=%0d, want 0 1 0 0 7",
                     t, bus.err, bus.res, bus.iters, bus.tag_out);
        end
        drain();
        do_op(2'b00, 12'd4095, 12'd4095, 12'd1, 4'd8, e, t);
        checks++;
        if (t !== 1'b0 || bus.err !== 1'b1 || bus.res !== 12'd0 || bus.iters !== CNTW'(8) || e != 10) begin
            failures++;
            $display("FAIL maxiter: tmo=%b err=%b res=%0d iters=%0d edges=%0d, want 0 1 0 8 10",
                     t, bus.err, bus.res, bus.iters, e);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int e; bit t; int bad;
        bus.out_rdy = 1'b0;
        do_op(2'b00, 12'd4000, 12'd4000, P, 4'd9, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd1342 || bus.iters !== CNTW'(2) || bus.tag_out !== 4'd9) begin
            failures++;
            $display("FAIL bp_result: tmo=%b res=%0d iters=%0d tag=%0d, want 0 1342 2 9",
                     t, bus.res, bus.iters, bus.tag_out);
        end
        // second request presented while the first result is stalled
        bus.in_vld = 1'b1;
        bus.mode   = 2'b00;
        bus.op1    = 12'd10;
        bus.op2    = 12'd20;
        bus.mod    = P;
        bus.tag_in = 4'd3;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b1 || bus.res !== 12'd1342 || bus.tag_out !== 4'd9 ||
                bus.in_rdy !== 1'b0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 6 stalled cycles unstable, want 0", bad);
        end
        bus.out_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: out_vld=%b in_rdy=%b, want 0 1", bus.out_vld, bus.in_rdy);
        end
        do_op(2'b00, 12'd10, 12'd20, P, 4'd3, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd30 || bus.tag_out !== 4'd3 || bus.iters !== CNTW'(0) || e != 2) begin
            failures++;
            $display("FAIL bp_second: tmo=%b res=%0d tag=%0d iters=%0d edges=%0d, want 0 30 3 0 2",
                     t, bus.res, bus.tag_out, bus.iters, e);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int e; bit t; int stale;
        // long reduction (p=1), reset while in REDUCE
        bus.in_vld = 1'b1;
        bus.mode   = 2'b00;
        bus.op1    = 12'd4095;
        bus.op2    = 12'd4095;
        bus.mod    = 12'd1;
        bus.tag_in = 4'd11;
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.in_rdy !== 1'b0) begin
            failures++;
            $display("FAIL rst_reduce: out_vld=%b in_rdy=%b, want 0 0", bus.out_vld, bus.in_rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b0) stale++;
        end
        checks++;
        if (stale != 0 || bus.in_rdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_stale: stale_cycles=%0d in_rdy=%b, want 0 1", stale, bus.in_rdy);
        end
        do_op(2'b00, 12'd1, 12'd2, P, 4'd12, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd3 || bus.err !== 1'b0 || bus.tag_out !== 4'd12) begin
            failures++;
            $display("FAIL rst_after_add: tmo=%b res=%0d err=%b tag=%0d, want 0 3 0 12",
                     t, bus.res, bus.err, bus.tag_out);
        end
        // reset while holding a result in DONE
        bus.out_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.res !== 12'd0 || bus.tag_out !== 4'd0) begin
            failures++;
            $display("FAIL rst_done: out_vld=%b res=%0d tag=%0d, want 0 0 0",
                     bus.out_vld, bus.res, bus.tag_out);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.out_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int e; bit t; int gap;
        do_op(2'b01, 12'd100, 12'd40, P, 4'd1, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd60 || e != 2) begin
            failures++;
            $display("FAIL b2b_first: tmo=%b res=%0d edges=%0d, want 0 60 2", t, bus.res, e);
        end
        // out_rdy high: handshake on the next edge, in_rdy back after that same edge
        gap = 0;
        @(negedge clk);
        gap++;
        checks++;
        if (bus.in_rdy !== 1'b1 || bus.out_vld !== 1'b0 || gap != 1) begin
            failures++;
            $display("FAIL b2b_turnaround: in_rdy=%b out_vld=%b, want 1 0", bus.in_rdy, bus.out_vld);
        end
        do_op(2'b00, 12'd3328, 12'd3328, P, 4'd2, e, t);
        checks++;
        if (t !== 1'b0 || bus.res !== 12'd3327 || bus.iters !== CNTW'(1) || bus.tag_out !== 4'd2) begin
            failures++;
            $display("FAIL b2b_second: tmo=%b res=%0d iters=%0d tag=%0d, want 0 3327 1 2",
                     t, bus.res, bus.iters, bus.tag_out);
        end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_add();
        test_sub();
        test_red();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
